// File: rtl/bus_timer.sv
// bus_timer: memory-mapped 16-bit down-counter with reload, expiry flag
// and irq/nmi routing. Ports: clk, clr (async reset), addr, rw, dataio, irq, nmi.
module bus_timer #(
  parameter logic [15:0] BASE = 16'hD000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [15:0] addr,
  input  logic        rw,
  inout  wire  [7:0]  dataio,
  output logic        irq,
  output logic        nmi
);

  logic [15:0] count;
  logic [15:0] reload;
  logic [7:0]  hishadow;
  logic        en;
  logic        ar;
  logic        ie;
  logic        nr;
  logic        flag;

  logic        cs;
  logic        rd;
  logic        wr;
  logic [1:0]  idx;
  logic [7:0]  din;
  logic [7:0]  rdata;
  logic        expire;

  logic        wr_cntl;
  logic        wr_cnth;
  logic        wr_ctrl;
  logic        wr_stat;
  logic        rd_cntl;

  assign cs  = (addr[15:2] == BASE[15:2]);
  assign idx = addr[1:0];
  // reads are suppressed during reset so the bus stays released
  assign rd  = cs & rw & ~clr;
  assign wr  = cs & ~rw;
  assign din = dataio;

  assign expire = en & (count == 16'h0000);

  always_comb begin
    wr_cntl = 1'b0;
    wr_cnth = 1'b0;
    wr_ctrl = 1'b0;
    wr_stat = 1'b0;
    rd_cntl = 1'b0;
    rdata   = 8'h00;
    unique case (idx)
      2'd0: begin
        wr_cntl = wr;
        rd_cntl = rd;
        rdata   = count[7:0];
      end
      2'd1: begin
        wr_cnth = wr;
        rdata   = hishadow;
      end
      2'd2: begin
        wr_ctrl = wr;
        rdata   = {4'h0, nr, ie, ar, en};
      end
      2'd3: begin
        wr_stat = wr;
        rdata   = {7'h00, flag};
      end
      default: rdata = 8'h00;
    endcase
  end

  assign dataio = rd ? rdata : 8'hzz;

  assign irq = flag & ie & ~nr;
  assign nmi = flag & ie & nr;

  // reload register and coherent high-byte snapshot
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      reload   <= 16'hFFFF;
      hishadow <= 8'h00;
    end else begin
      if (wr_cntl) reload[7:0]  <= din;
      if (wr_cnth) reload[15:8] <= din;
      if (rd_cntl) hishadow     <= count[15:8];
    end
  end

  // expiry always sets the flag, even against a same-cycle clear
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      flag <= 1'b0;
    end else if (expire) begin
      flag <= 1'b1;
    end else if (wr_stat && din[0]) begin
      flag <= 1'b0;
    end
  end

  // counter and control; a CNTH load outranks the expiry update,
  // and a CTRL write outranks the one-shot EN clear
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count <= 16'hFFFF;
      en    <= 1'b0;
      ar    <= 1'b0;
      ie    <= 1'b0;
      nr    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        nr <= din[3];
        ie <= din[2];
        ar <= din[1];
      end
      if (wr_cnth) begin
        count <= {din, reload[7:0]};
        en    <= 1'b1;
      end else begin
        if (en) begin
          if (count != 16'h0000) begin
            count <= count - 16'h0001;
          end else if (ar) begin
            count <= reload;
          end
        end
        if (wr_ctrl) begin
          en <= din[0];
        end else if (expire && !ar) begin
          en <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// tb_bus_timer: directed + randomized bench for bus_timer against a
// cycle-level behavioural model of the register rules.
module tb_bus_timer;

  localparam logic [15:0] BASE = 16'hD000;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [15:0] addr = BASE + 16'h0010;
  logic        rw = 1'b1;
  logic        tb_en = 1'b0;
  logic [7:0]  tb_dat = 8'h00;
  wire  [7:0]  dataio;
  logic        irq;
  logic        nmi;

  assign dataio = tb_en ? tb_dat : 8'hzz;

  bus_timer #(.BASE(BASE)) dut (
    .clk    (clk),
    .clr    (clr),
    .addr   (addr),
    .rw     (rw),
    .dataio (dataio),
    .irq    (irq),
    .nmi    (nmi)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [15:0] m_cnt;
  logic [15:0] m_rld;
  logic [7:0]  m_sh;
  logic        m_en, m_ar, m_ie, m_nr, m_flag;
  logic [7:0]  rdv;

  task automatic mreset();
    m_cnt = 16'hFFFF;
    m_rld = 16'hFFFF;
    m_sh = 8'h00;
    {m_nr, m_ie, m_ar, m_en} = 4'h0;
    m_flag = 1'b0;
  endtask

  function automatic logic [7:0] mrd(input logic [1:0] i);
    case (i)
      2'd0: return m_cnt[7:0];
      2'd1: return m_sh;
      2'd2: return {4'h0, m_nr, m_ie, m_ar, m_en};
      default: return {7'h00, m_flag};
    endcase
  endfunction

  // kind: 0 idle, 1 read, 2 write, 3 out-of-window read probe
  task automatic mstep(input int kind, input logic [1:0] i,
                       input logic [7:0] d);
    logic        ex;
    logic        w;
    logic [15:0] orld;
    ex = m_en && (m_cnt == 16'h0000);
    w = (kind == 2);
    orld = m_rld;
    if (kind == 1 && i == 2'd0) m_sh = m_cnt[15:8];
    if (ex) m_flag = 1'b1;
    else if (w && i == 2'd3 && d[0]) m_flag = 1'b0;
    if (m_en) begin
      if (m_cnt != 0) m_cnt = m_cnt - 1;
      else if (m_ar) m_cnt = orld;
      else m_en = 1'b0;
    end
    if (w && i == 2'd2) {m_nr, m_ie, m_ar, m_en} = d[3:0];
    if (w && i == 2'd1) begin
      m_cnt = {d, orld[7:0]};
      m_en = 1'b1;
    end
    if (w && i == 2'd0) m_rld[7:0] = d;
    if (w && i == 2'd1) m_rld[15:8] = d;
  endtask

  task automatic cyc(input int kind, input logic [1:0] i,
                     input logic [7:0] d);
    @(negedge clk);
    addr = (kind == 1 || kind == 2) ? BASE + {14'd0, i}
                                    : BASE + 16'h0010;
    rw = (kind != 2);
    tb_en = (kind == 2 || kind == 3);
    tb_dat = (kind == 2) ? d : 8'h00;
    #1;
    if (kind == 1) begin
      rdv = dataio;
      chk($sformatf("rd%0d", i), rdv, mrd(i));
    end
    if (kind == 3) chk("hiz_out", dataio, 16'h0000);
    @(posedge clk);
    mstep(kind, i, d);
    #1;
    chk("irq", irq, m_flag & m_ie & ~m_nr);
    chk("nmi", nmi, m_flag & m_ie & m_nr);
    addr = BASE + 16'h0010;
    rw = 1'b1;
    tb_en = 1'b0;
  endtask

  task automatic wr(input logic [1:0] i, input logic [7:0] d);
    cyc(2, i, d);
  endtask

  task automatic rd(input logic [1:0] i);
    cyc(1, i, 8'h00);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 2'd0, 8'h00);
  endtask

  // asynchronous reset asserted between clock edges
  task automatic do_reset();
    @(negedge clk);
    #2 clr = 1'b1;
    #1;
    mreset();
    chk("rst_irq", irq, 16'h0000);
    chk("rst_nmi", nmi, 16'h0000);
    addr = BASE;
    rw = 1'b1;
    tb_en = 1'b1;
    tb_dat = 8'h00;
    #1 chk("rst_hiz", dataio, 16'h0000);
    tb_en = 1'b0;
    addr = BASE + 16'h0010;
    @(posedge clk);
    #1 chk("rst_irq_clk", irq, 16'h0000);
    clr = 1'b0;
  endtask

  initial begin
    mreset();
    @(posedge clk);
    #1;
    chk("por_irq", irq, 16'h0000);
    chk("por_nmi", nmi, 16'h0000);
    clr = 1'b0;

    rd(2'd0); chk("por_cntl", rdv, 16'h00FF);
    rd(2'd1); chk("por_cnth", rdv, 16'h00FF);
    rd(2'd2); chk("por_ctrl", rdv, 16'h0000);
    rd(2'd3); chk("por_stat", rdv, 16'h0000);
    cyc(3, 2'd0, 8'h00);

    // one-shot
    wr(2'd0, 8'h03);
    wr(2'd2, 8'h04);
    wr(2'd1, 8'h00);
    idle(3); chk("os_pre", irq, 16'h0000);
    idle(1); chk("os_irq", irq, 16'h0001);
    rd(2'd2); chk("os_ctrl", rdv, 16'h0004);
    rd(2'd0); chk("os_cnt", rdv, 16'h0000);

    // auto-reload period of reload+1
    wr(2'd2, 8'h06);
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h04);
    wr(2'd1, 8'h00);
    idle(4); chk("ar_pre", irq, 16'h0000);
    idle(1); chk("ar_exp1", irq, 16'h0001);
    wr(2'd3, 8'h01); chk("ar_clr", irq, 16'h0000);
    idle(3); chk("ar_gap", irq, 16'h0000);
    idle(1); chk("ar_exp2", irq, 16'h0001);

    // coherent 16-bit read
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h01);
    rd(2'd0); chk("coh_lo", rdv, 16'h0000);
    rd(2'd1); chk("coh_hi", rdv, 16'h0001);

    // nmi routing
    wr(2'd2, 8'h00);
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h02);
    wr(2'd2, 8'h0D);
    wr(2'd1, 8'h00);
    idle(3);
    chk("nmi_set", nmi, 16'h0001);
    chk("nmi_noirq", irq, 16'h0000);
    wr(2'd2, 8'h09); chk("nmi_ie0", nmi, 16'h0000);
    rd(2'd3); chk("nmi_stat", rdv, 16'h0001);

    // STAT clear colliding with expiry
    wr(2'd2, 8'h04);
    wr(2'd3, 8'h01);
    wr(2'd0, 8'h00);
    wr(2'd1, 8'h00);
    wr(2'd3, 8'h01);
    rd(2'd3); chk("col_stat", rdv, 16'h0001);

    // CNTH write colliding with expiry (reload 0 expires every clock)
    wr(2'd2, 8'h03);
    wr(2'd0, 8'h34);
    wr(2'd1, 8'h12);
    rd(2'd0); chk("col_lo", rdv, 16'h0034);
    rd(2'd1); chk("col_hi", rdv, 16'h0012);
    rd(2'd2); chk("col_ctrl", rdv, 16'h0003);

    // reset mid-count, then nothing counts
    wr(2'd2, 8'h07); chk("pre_rst_irq", irq, 16'h0001);
    do_reset();
    idle(3);
    rd(2'd0); chk("post_rst_cnt", rdv, 16'h00FF);
    rd(2'd2); chk("post_rst_ctrl", rdv, 16'h0000);

    // randomized traffic
    repeat (3000) begin
      int r;
      logic [1:0] i;
      logic [7:0] d;
      r = $urandom_range(0, 99);
      i = 2'($urandom_range(0, 3));
      d = 8'($urandom);
      if ((i == 2'd0 || i == 2'd1) && $urandom_range(0, 9) != 0)
        d = 8'($urandom_range(0, 6));
      if (r == 0) do_reset();
      else if (r < 30) idle(1);
      else if (r < 33) cyc(3, 2'd0, 8'h00);
      else if (r < 60) rd(i);
      else wr(i, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
BUS_TIMER -- requirements
Module: bus_timer

Interface
REQ-001 Parameter BASE, default 16'hD000, SHALL set the 4-byte register window BASE..BASE+3; BASE[1:0] is 2'b00.
REQ-002 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-003 clr  input  1  asynchronous, active-high reset.
REQ-004 addr  input  16  CPU address bus, {abh,abl}.
REQ-005 rw  input  1  1 = CPU read, 0 = CPU write.
REQ-006 dataio  inout  8  CPU data bus; SHALL be high-Z unless this block is driving a read.
REQ-007 irq  output  1  active-high maskable interrupt request to the CPU.
REQ-008 nmi  output  1  active-high non-maskable interrupt request to the CPU (level output; the CPU edge-detects).

Function
REQ-009 cs SHALL be asserted when addr[15:2] == BASE[15:2]; the register index is addr[1:0].
REQ-010 Register map: 0 CNTL (read count[7:0], write reload[7:0]); 1 CNTH (read latched high byte, write reload[15:8]); 2 CTRL (read/write); 3 STAT (bit0 = expired flag).
REQ-011 CTRL bits: bit0 EN (count enable), bit1 AR (auto-reload), bit2 IE (interrupt enable), bit3 NR (route to nmi); bits 7:4 SHALL read 0 and ignore writes.
REQ-012 Writes SHALL be captured on the rising clk when cs=1 and rw=0.
REQ-013 Reads SHALL be combinational: dataio is driven with the selected register while cs=1 and rw=1, otherwise high-Z.
REQ-014 A CNTL write SHALL update reload[7:0] only; the counter is unaffected.
REQ-015 A CNTH write SHALL update reload[15:8], load count <= {new high byte, reload[7:0]}, and set EN in the same edge.
REQ-016 A CNTL read, on the rising clk where it is active, SHALL latch count[15:8] into hishadow; CNTH reads SHALL return hishadow, giving a coherent 16-bit snapshot.
REQ-017 While EN=1 and count!=0, count SHALL decrement by 1 per clk.
REQ-018 While EN=1 and count==0 (expiry), the next clk SHALL set flag.
REQ-019 On expiry with AR=1, count SHALL load reload and EN SHALL stay 1; the period is therefore reload+1 clocks.
REQ-020 On expiry with AR=0, count SHALL stay 0 and EN SHALL clear (one-shot).
REQ-021 While EN=0, count SHALL hold its value.
REQ-022 Writing STAT with data bit0=1 SHALL clear flag; writing bit0=0 SHALL have no effect.
REQ-023 Expiry and a STAT clear in the same cycle: the set SHALL win and flag ends at 1.
REQ-024 A CNTH write in the same cycle as an expiry: the CNTH load of count and EN SHALL win over the expiry update, and flag SHALL still set.
REQ-025 A CTRL write clearing EN in the same cycle as an expiry: the expiry flag SHALL set, and EN SHALL end at 0.
REQ-026 Interrupt outputs, combinational from registers:
- irq = flag & IE & ~NR
- nmi = flag & IE & NR
REQ-027 The outputs SHALL remain asserted until flag is cleared or IE is cleared.
REQ-028 Reload value 0 with AR=1 SHALL expire on every clk, with flag held at 1.

Reset
REQ-029 While clr=1, the block SHALL hold, independent of clk:
- count = 16'hFFFF, reload = 16'hFFFF
- hishadow = 8'h00, CTRL = 8'h00, flag = 0
- irq = 0, nmi = 0, dataio high-Z
REQ-030 Asserting clr mid-count SHALL abort counting immediately; after clr falls, nothing counts until the next CNTH write or a CTRL write that sets EN.

Verification
REQ-031 One-shot: write CNTL=8'h03, CTRL=8'h04, CNTH=8'h00 -> count runs 3,2,1,0; flag=1 and irq=1 at the 4th clk after the CNTH write; EN reads 0; count holds 0.
REQ-032 Auto-reload period: reload=16'h0004, CTRL=8'h06, CNTH write -> flag sets every 5 clks; clearing via STAT write 8'h01 between expiries drops irq for exactly the gap.
REQ-033 NMI routing: CTRL=8'h0D, count expires -> nmi=1 and irq=0; clear IE with CTRL=8'h09 -> nmi=0 while STAT still reads 8'h01.
REQ-034 Coherent read: count=16'h0100, free-running -> CNTL read returns 8'h00 and the CNTH read one clock later returns 8'h01, even though live count[15:8]=8'h00.
REQ-035 Collisions:
- STAT clear in the same cycle as expiry -> STAT reads 8'h01.
- CNTH write 8'h12 (reload low 8'h34) during expiry -> count=16'h1234, EN=1.
REQ-036 Reset and bus behaviour:
- Assert clr mid-count -> count=16'hFFFF, CTRL=8'h00, irq=0 within the same timestep, no clk needed.
- Read with addr outside the window -> dataio stays high-Z.
